// File: rtl/seg7_hex_scan.sv
// Four-digit multiplexed hex display driver with shadowed value, decimal point,
// leading-zero blanking and a free-running blink for the negative indicator.
module seg7_hex_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        dp_en,
  input  logic [1:0]  dp_pos,
  input  logic        neg,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        neg_led
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [RW-1:0] rcnt_q;
  logic [1:0]    idx_q;
  logic [BW-1:0] bcnt_q;
  logic          blink_q;
  logic          tick;
  logic          bwrap;

  logic [15:0]   sh_val_q;
  logic          sh_dpen_q;
  logic [1:0]    sh_dppos_q;
  logic          sh_neg_q;

  logic [3:0]    nib;
  logic [15:0]   upper;
  logic          blank;
  logic [6:0]    hex_d;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;
  logic          dp_d;
  logic          neg_led_d;

  assign tick  = (rcnt_q == RW'(REFRESH_DIV - 1));
  assign bwrap = (bcnt_q == BW'(BLINK_DIV - 1));

  // Refresh prescaler and digit index; a load never disturbs the scan.
  always_ff @(posedge clk) begin
    if (clr) begin
      rcnt_q <= '0;
      idx_q  <= '0;
    end else if (tick) begin
      rcnt_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      rcnt_q <= rcnt_q + RW'(1);
    end
  end

  // Blink half-period counter; blink toggles on each wrap.
  always_ff @(posedge clk) begin
    if (clr) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (bwrap) begin
      bcnt_q  <= '0;
      blink_q <= ~blink_q;
    end else begin
      bcnt_q  <= bcnt_q + BW'(1);
    end
  end

  // Shadow registers capture the display word on load.
  always_ff @(posedge clk) begin
    if (clr) begin
      sh_val_q   <= '0;
      sh_dpen_q  <= 1'b0;
      sh_dppos_q <= '0;
      sh_neg_q   <= 1'b0;
    end else if (load) begin
      sh_val_q   <= value;
      sh_dpen_q  <= dp_en;
      sh_dppos_q <= dp_pos;
      sh_neg_q   <= neg;
    end
  end

  // Current digit decode: nibble, hex pattern, blanking, anode and dp.
  always_comb begin
    nib   = sh_val_q[{idx_q, 2'b00} +: 4];
    upper = sh_val_q >> {idx_q, 2'b00};
    hex_d = 7'h7F;
    unique case (nib)
      4'h0: hex_d = 7'h40;
      4'h1: hex_d = 7'h79;
      4'h2: hex_d = 7'h24;
      4'h3: hex_d = 7'h30;
      4'h4: hex_d = 7'h19;
      4'h5: hex_d = 7'h12;
      4'h6: hex_d = 7'h02;
      4'h7: hex_d = 7'h78;
      4'h8: hex_d = 7'h00;
      4'h9: hex_d = 7'h10;
      4'hA: hex_d = 7'h08;
      4'hB: hex_d = 7'h03;
      4'hC: hex_d = 7'h46;
      4'hD: hex_d = 7'h21;
      4'hE: hex_d = 7'h06;
      4'hF: hex_d = 7'h0E;
    endcase
    // Digits at or right of the decimal point always show, as does digit 0.
    blank = blank_lz && (idx_q != 2'd0) && (upper == 16'h0000)
            && !(sh_dpen_q && (idx_q <= sh_dppos_q));
    seg_d     = blank ? 7'h7F : hex_d;
    an_d      = ~(4'b0001 << idx_q);
    dp_d      = !(sh_dpen_q && (idx_q == sh_dppos_q));
    neg_led_d = blink_q & sh_neg_q;
  end

  // Registered pins; dark while in reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      seg     <= 7'h7F;
      an      <= 4'hF;
      dp      <= 1'b1;
      neg_led <= 1'b0;
    end else begin
      seg     <= seg_d;
      an      <= an_d;
      dp      <= dp_d;
      neg_led <= neg_led_d;
    end
  end

endmodule

// File: tb/tb_seg7_hex_scan.sv
// Bench for seg7_hex_scan: directed scenarios followed by random traffic,
// every cycle compared against a closed-form model of the display.
module tb_seg7_hex_scan;

  localparam int R = 4;
  localparam int B = 8;

  logic        clk = 1'b0;
  logic        clr, load, dp_en, neg, blank_lz;
  logic [15:0] value;
  logic [1:0]  dp_pos;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp, neg_led;

  always #5 clk = ~clk;

  seg7_hex_scan #(
    .REFRESH_DIV(R),
    .BLINK_DIV  (B)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .load    (load),
    .value   (value),
    .dp_en   (dp_en),
    .dp_pos  (dp_pos),
    .neg     (neg),
    .blank_lz(blank_lz),
    .seg     (seg),
    .an      (an),
    .dp      (dp),
    .neg_led (neg_led)
  );

  // Model: k = clean edges since reset; shadow copy of the last load.
  int          k;
  logic [15:0] m_val;
  logic        m_dpen;
  logic [1:0]  m_dppos;
  logic        m_neg;
  logic        cur_blz;
  int          checks;
  int          failures;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic step(input logic c, input logic ld, input logic [15:0] v, input logic de,
                      input logic [1:0] dpp, input logic ng, input logic blz);
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp, e_neg;
    int         i;
    logic       bl;
    clr = c; load = ld; value = v; dp_en = de; dp_pos = dpp; neg = ng; blank_lz = blz;
    @(posedge clk);
    if (c) begin
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1; e_neg = 1'b0;
      k = 0; m_val = '0; m_dpen = 1'b0; m_dppos = '0; m_neg = 1'b0;
    end else begin
      i     = (k / R) % 4;
      bl    = blz && (i != 0) && ((m_val >> (4 * i)) == 16'h0)
              && !(m_dpen && (i <= int'(m_dppos)));
      e_seg = bl ? 7'h7F : hex7(4'((m_val >> (4 * i)) & 16'hF));
      e_an  = 4'hF & ~(4'h1 << i);
      e_dp  = !(m_dpen && (i == int'(m_dppos)));
      e_neg = (((k / B) % 2) == 1) && m_neg;
      k++;
      if (ld) begin
        m_val = v; m_dpen = de; m_dppos = dpp; m_neg = ng;
      end
    end
    #1;
    chk("seg", seg, e_seg);
    chk("an", 7'(an), 7'(e_an));
    chk("dp", 7'(dp), 7'(e_dp));
    chk("neg_led", 7'(neg_led), 7'(e_neg));
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0, cur_blz);
  endtask

  task automatic ld(input logic [15:0] v, input logic de, input logic [1:0] dpp,
                    input logic ng);
    step(1'b0, 1'b1, v, de, dpp, ng, cur_blz);
  endtask

  initial begin
    checks = 0; failures = 0; k = 0; cur_blz = 1'b0;
    m_val = '0; m_dpen = 1'b0; m_dppos = '0; m_neg = 1'b0;
    // Reset, then a plain scan of the reset shadow.
    step(1'b1, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 1'b1, 2'd1, 1'b1, 1'b0);
    idle(16);
    // Hex digits without blanking.
    ld(16'hA5C3, 1'b0, 2'd0, 1'b0);
    idle(16);
    // Leading-zero blanking, then with a decimal point at digit 2.
    cur_blz = 1'b1;
    ld(16'h0007, 1'b0, 2'd0, 1'b0);
    idle(16);
    ld(16'h0007, 1'b1, 2'd2, 1'b0);
    idle(16);
    // Negative blink, then clearing neg.
    ld(16'h0007, 1'b1, 2'd2, 1'b1);
    idle(20);
    ld(16'h0007, 1'b1, 2'd2, 1'b0);
    idle(2);
    // Load coinciding with a digit tick.
    cur_blz = 1'b0;
    for (int j = 0; j < R && (k % R) != R - 1; j++) idle(1);
    ld(16'hFFFF, 1'b0, 2'd0, 1'b0);
    idle(4);
    // Reset while in the digit-2 slot, then resume.
    for (int j = 0; j < 4 * R && ((k / R) % 4) != 2; j++) idle(1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0, cur_blz);
    idle(8);
    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 6) == 0),
           16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom),
           1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 9) != 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
